// File: rtl/fir_stream.sv
// Streaming FIR filter: NTAPS signed taps, run-time coefficients, rounding shift, wrap or clamp (FIR_SATURATE_EN) output.
// Latency: a sample accepted in cycle N produces y_vld in cycle N+2; one sample per cycle sustained.
// Backpressure: y_vld & ~y_rdy freezes the whole pipeline and drops x_rdy; outputs are held, never dropped or duplicated.
module fir_stream #(
    parameter int DW    = 32,
    parameter int CW    = 16,
    parameter int NTAPS = 8,
    parameter int OW    = 32,
    parameter int SHIFT = 0,
    localparam int AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] x_rsc_dat,
    input  logic          x_vld,
    output logic          x_rdy,
    output logic [OW-1:0] y_rsc_dat,
    output logic          y_vld,
    input  logic          y_rdy,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_dat,
    input  logic          clr
);

    // Full-precision accumulator, plus one guard bit so the rounding add can never overflow.
    localparam int ACCW = DW + CW + AW;
    localparam int RW   = ACCW + 1;

    logic signed [CW-1:0]   coef_r  [NTAPS];
    logic signed [DW-1:0]   dly     [NTAPS];
    logic signed [DW-1:0]   dly_nxt [NTAPS];
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] acc;
    logic                   s1_vld;
    logic                   stall;
    logic                   accept;
    logic signed [RW-1:0]   acc_ext;
    logic signed [RW-1:0]   r;
    logic signed [OW-1:0]   y_fit;

    assign stall  = y_vld & ~y_rdy;
    assign x_rdy  = ~stall;
    assign accept = x_vld & x_rdy;

    // Next delay-line contents: clear wipes history first, an accepted sample then enters tap 0.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            dly_nxt[k] = clr ? '0 : dly[k];
        end
        if (accept) begin
            dly_nxt[0] = $signed(x_rsc_dat);
            for (int k = 1; k < NTAPS; k++) begin
                dly_nxt[k] = clr ? '0 : dly[k-1];
            end
        end
    end

    // Dot product over the line including this cycle's sample; operands widened before the multiply.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum = sum + ACCW'(coef_r[k]) * ACCW'(dly_nxt[k]);
        end
    end

    assign acc_ext = RW'(acc);

    // Round half up before the arithmetic shift; no shift means the accumulator passes straight through.
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
            assign r = (acc_ext + HALF) >>> SHIFT;
        end else begin : g_pass
            assign r = acc_ext;
        end
    endgenerate

    // Fit the result into OW bits: sign-extend when wide enough, else clamp or wrap.
    generate
        if (OW >= RW) begin : g_wide
            assign y_fit = OW'(r);
        end else begin : g_narrow
`ifdef FIR_SATURATE_EN
            localparam logic signed [RW-1:0] YMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [RW-1:0] YMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};
            assign y_fit = (r > YMAX) ? OW'(YMAX) :
                           (r < YMIN) ? OW'(YMIN) : OW'(r);
`else
            assign y_fit = OW'(r);
`endif
        end
    endgenerate

    // Coefficient table: identity filter out of reset, single-tap writes at any time; bad addresses ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef_r[k] <= '0;
            end
            coef_r[0] <= CW'(1);
        end else if (coef_we && (int'(coef_addr) < NTAPS)) begin
            coef_r[coef_addr] <= $signed(coef_dat);
        end
    end

    // Delay line: dly_nxt already equals dly when nothing is accepted or cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                dly[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                dly[k] <= dly_nxt[k];
            end
        end
    end

    // Stage 1: register the dot product; clear forces an update even while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            s1_vld <= 1'b0;
        end else if (clr || !stall) begin
            acc    <= sum;
            s1_vld <= accept;
        end
    end

    // Stage 2: output register; data only moves with a valid result so bubbles hold the last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_rsc_dat <= '0;
            y_vld     <= 1'b0;
        end else if (clr) begin
            y_vld <= 1'b0;
        end else if (!stall) begin
            y_vld <= s1_vld;
            if (s1_vld) begin
                y_rsc_dat <= y_fit;
            end
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
module tb_fir_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x_dat = '0;
    logic        x_vld = 1'b0;
    logic        y_rdy = 1'b1;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_dat = '0;
    logic        clr = 1'b0;

    logic [31:0] y0;  logic yv0; logic xr0;
    logic [15:0] y1;  logic yv1; logic xr1;
    logic [31:0] y2;  logic yv2; logic xr2;

    int errors = 0;
    int checks = 0;

    logic [31:0] q0[$];
    logic [15:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    fir_stream u_dut (
        .clk(clk), .rst(rst), .x_rsc_dat(x_dat), .x_vld(x_vld), .x_rdy(xr0),
        .y_rsc_dat(y0), .y_vld(yv0), .y_rdy(y_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_dat(coef_dat), .clr(clr)
    );

    fir_stream #(.OW(16)) u_ow16 (
        .clk(clk), .rst(rst), .x_rsc_dat(x_dat), .x_vld(x_vld), .x_rdy(xr1),
        .y_rsc_dat(y1), .y_vld(yv1), .y_rdy(y_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_dat(coef_dat), .clr(clr)
    );

    fir_stream #(.SHIFT(2)) u_sh2 (
        .clk(clk), .rst(rst), .x_rsc_dat(x_dat), .x_vld(x_vld), .x_rdy(xr2),
        .y_rsc_dat(y2), .y_vld(yv2), .y_rdy(y_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_dat(coef_dat), .clr(clr)
    );

    task automatic set_in(input logic v, input int x, input logic rdy);
        x_vld = v;
        x_dat = 32'(x);
        y_rdy = rdy;
        #1;
    endtask

    // Record outputs that transfer at the coming edge, then advance one cycle.
    task automatic step(output logic acc);
        acc = x_vld && xr0;
        if (yv0 && y_rdy) begin
            q0.push_back(y0);
            q1.push_back(y1);
            q2.push_back(y2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int xs[8], input int n);
        int   idx;
        logic a;
        idx = 0;
        for (int c = 0; c < n + 6; c++) begin
            set_in(idx < n, (idx < n) ? xs[idx] : 0, 1'b1);
            step(a);
            if (a) idx++;
        end
        x_vld = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_dat  = 16'(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        x_vld = 1'b0;
        clr   = 1'b0;
        y_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (yv0 !== 1'b0) begin errors++; $display("FAIL reset_yvld got=%b want=0", yv0); end
        checks++; if (y0 !== 32'd0) begin errors++; $display("FAIL reset_y got=%h want=0", y0); end
        checks++; if (xr0 !== 1'b1) begin errors++; $display("FAIL reset_xrdy got=%b want=1", xr0); end
        checks++; if (yv2 !== 1'b0) begin errors++; $display("FAIL reset_yvld_sh2 got=%b want=0", yv2); end
        do_reset();
    endtask

    task automatic test_identity();
        logic a;
        for (int c = 0; c < 7; c++) begin
            set_in(c < 5, c + 1, 1'b1);
            step(a);
            checks++;
            if (yv0 !== ((c >= 1) && (c <= 5))) begin
                errors++; $display("FAIL ident_vld cyc=%0d got=%b want=%b", c, yv0, (c >= 1) && (c <= 5));
            end
            if ((c >= 1) && (c <= 5)) begin
                checks++;
                if (y0 !== 32'(c)) begin errors++; $display("FAIL ident_y cyc=%0d got=%0d want=%0d", c, y0, c); end
            end
        end
        x_vld = 1'b0;
    endtask

    task automatic test_impulse();
        int exp[6] = '{1, 2, 3, 4, 0, 0};
        do_reset();
        wr_coef(0, 1); wr_coef(1, 2); wr_coef(2, 3); wr_coef(3, 4);
        q0.delete();
        feed('{1, 0, 0, 0, 0, 0, 0, 0}, 6);
        checks++; if (q0.size() != 6) begin errors++; $display("FAIL impulse_count got=%0d want=6", q0.size()); end
        for (int i = 0; i < 6 && i < q0.size(); i++) begin
            checks++;
            if (q0[i] !== 32'(exp[i])) begin errors++; $display("FAIL impulse_y i=%0d got=%0d want=%0d", i, q0[i], exp[i]); end
        end
    endtask

    task automatic test_stall();
        int   idx;
        logic a;
        logic st;
        do_reset();
        wr_coef(1, 1);
        q0.delete();
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            st = (c >= 3) && (c < 6);
            set_in(idx < 6, idx + 1, !st);
            if (st) begin
                checks++; if (xr0 !== 1'b0) begin errors++; $display("FAIL stall_xrdy cyc=%0d got=%b want=0", c, xr0); end
                checks++; if (yv0 !== 1'b1) begin errors++; $display("FAIL stall_yvld cyc=%0d got=%b want=1", c, yv0); end
                checks++; if (y0 !== 32'd3) begin errors++; $display("FAIL stall_hold cyc=%0d got=%0d want=3", c, y0); end
            end
            step(a);
            if (a) idx++;
        end
        x_vld = 1'b0;
        checks++; if (q0.size() != 6) begin errors++; $display("FAIL stall_count got=%0d want=6", q0.size()); end
        for (int i = 0; i < 6 && i < q0.size(); i++) begin
            checks++;
            if (q0[i] !== 32'(2 * i + 1)) begin errors++; $display("FAIL stall_y i=%0d got=%0d want=%0d", i, q0[i], 2 * i + 1); end
        end
    endtask

    task automatic test_clear();
        logic a;
        set_in(1'b1, 5, 1'b1); step(a);
        set_in(1'b1, 7, 1'b1); step(a);
        clr = 1'b1;
        set_in(1'b0, 0, 1'b1); step(a);
        clr = 1'b0;
        checks++; if (yv0 !== 1'b0) begin errors++; $display("FAIL clr_yvld got=%b want=0", yv0); end
        q0.delete();
        feed('{1, 2, 0, 0, 0, 0, 0, 0}, 2);
        checks++; if (q0.size() != 2) begin errors++; $display("FAIL clr_count got=%0d want=2", q0.size()); end
        if (q0.size() == 2) begin
            checks++; if (q0[0] !== 32'd1) begin errors++; $display("FAIL clr_first got=%0d want=1", q0[0]); end
            checks++; if (q0[1] !== 32'd3) begin errors++; $display("FAIL clr_coef_kept got=%0d want=3", q0[1]); end
        end
    endtask

    task automatic test_narrow();
        logic [15:0] e0, e3, e7;
        logic        a;
`ifdef FIR_SATURATE_EN
        e0 = 16'h7FFF; e3 = 16'h7FFF; e7 = 16'h7FFF;
`else
        e0 = 16'h8001; e3 = 16'h0004; e7 = 16'h0008;
`endif
        clr = 1'b1;
        set_in(1'b0, 0, 1'b1); step(a);
        clr = 1'b0;
        for (int k = 0; k < 8; k++) wr_coef(k, 32767);
        q1.delete(); q0.delete(); q2.delete();
        feed('{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
               32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 8);
        checks++; if (q1.size() != 8) begin errors++; $display("FAIL narrow_count got=%0d want=8", q1.size()); end
        if (q1.size() == 8) begin
            checks++; if (q1[0] !== e0) begin errors++; $display("FAIL narrow_y0 got=%h want=%h", q1[0], e0); end
            checks++; if (q1[3] !== e3) begin errors++; $display("FAIL narrow_y3 got=%h want=%h", q1[3], e3); end
            checks++; if (q1[7] !== e7) begin errors++; $display("FAIL narrow_y7 got=%h want=%h", q1[7], e7); end
        end
    endtask

    task automatic test_shift_and_reset();
        int   exp[5] = '{2, -1, 1, 0, 1};
        logic a;
        do_reset();
        feed('{6, -6, 2, -2, 5, 0, 0, 0}, 5);
        checks++; if (q2.size() != 5) begin errors++; $display("FAIL shift_count got=%0d want=5", q2.size()); end
        for (int i = 0; i < 5 && i < q2.size(); i++) begin
            checks++;
            if (q2[i] !== 32'(exp[i])) begin errors++; $display("FAIL shift_y i=%0d got=%0d want=%0d", i, $signed(q2[i]), exp[i]); end
        end
        set_in(1'b1, 3, 1'b1); step(a);
        set_in(1'b1, 4, 1'b1); step(a);
        checks++; if (yv2 !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b want=1", yv2); end
        rst = 1'b0;
        #1;
        checks++; if (yv2 !== 1'b0) begin errors++; $display("FAIL midrst_yvld got=%b want=0", yv2); end
        checks++; if (y2 !== 32'd0) begin errors++; $display("FAIL midrst_y got=%h want=0", y2); end
        checks++; if (xr2 !== 1'b1) begin errors++; $display("FAIL midrst_xrdy got=%b want=1", xr2); end
        x_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(1'b0, 0, 1'b1); step(a); step(a);
        checks++; if (yv2 !== 1'b0) begin errors++; $display("FAIL midrst_lost got=%b want=0", yv2); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_impulse();
        test_stall();
        test_clear();
        test_narrow();
        test_shift_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
